// File: rtl/pipe_lsu.sv
// rtl/pipe_lsu.sv - memory-stage load/store unit bridging the M stage to a valid/ready data bus
module pipe_lsu #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] alu_o_M,
    input  logic [31:0] wr_data_M,
    output logic [31:0] rd_data_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic        bus_err_M,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    state;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic [CW-1:0] tcnt;

    logic        access;
    logic        legal_f3;
    logic        aligned;
    logic        ok;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ext;
    logic        timed_out;

    // A store wins when both mem_rd_M and mem_wr_M are raised.
    always_comb begin
        access   = (mem_rd_M | mem_wr_M) & ~flush;
        legal_f3 = 1'b0;
        case (funct3_M)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = ~mem_wr_M;
            default:                legal_f3 = 1'b0;
        endcase
        case (funct3_M[1:0])
            2'b01:   aligned = ~alu_o_M[0];
            2'b10:   aligned = (alu_o_M[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        ok = legal_f3 & aligned;
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = wr_data_M;
        if (mem_wr_M) begin
            case (funct3_M[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << alu_o_M[1:0];
                    wdata_n = {4{wr_data_M[7:0]}};
                end
                2'b01: begin
                    be_n    = alu_o_M[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{wr_data_M[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = wr_data_M;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    bsel = rsp_rdata[7:0];
            2'd1:    bsel = rsp_rdata[15:8];
            2'd2:    bsel = rsp_rdata[23:16];
            default: bsel = rsp_rdata[31:24];
        endcase
        hsel = off_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{bsel[7]}}, bsel};
            3'b001:  ext = {{16{hsel[15]}}, hsel};
            3'b100:  ext = {24'd0, bsel};
            3'b101:  ext = {16'd0, hsel};
            default: ext = rsp_rdata;
        endcase
    end

    assign timed_out = (tcnt >= T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            f3_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && ok) begin
                        addr_q  <= {alu_o_M[31:2], 2'b00};
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        we_q    <= mem_wr_M;
                        off_q   <= alu_o_M[1:0];
                        f3_q    <= funct3_M;
                        data_q  <= '0;
                        err_q   <= 1'b0;
                        tcnt    <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    tcnt <= tcnt + 1'b1;
                    if (req_ready) begin
                        state <= we_q ? S_DONE : S_WAIT;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (rsp_valid) begin
                        data_q <= ext;
                        state  <= S_DONE;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The IDLE-cycle flags are combinational, so they are gated by reset to read 0 during it.
    assign stall_M    = rst & (((state == S_IDLE) & access & ok) | (state == S_REQ) | (state == S_WAIT));
    assign misalign_M = rst & (state == S_IDLE) & access & ~ok;
    assign bus_err_M  = (state == S_DONE) & err_q;
    assign rd_data_M  = (state == S_DONE) ? data_q : 32'd0;
    assign req_valid  = (state == S_REQ);
    assign req_we     = we_q;
    assign req_addr   = addr_q;
    assign req_be     = be_q;
    assign req_wdata  = wdata_q;

endmodule

// File: doc/pipe_lsu.md
Name: pipe_lsu

Overview:
- Memory-stage load/store unit: turns M-stage load/store controls and ALU address into a valid/ready data-memory bus transaction, then returns the extracted load data (rd_data_M) to the MEM/WB pipeline register.
- Drives the pipeline stall for the memory stage while a transaction is outstanding.
- Sits between the execute/memory pipeline register and the data memory (or bus bridge).

Parameters:
- TIMEOUT_CYC, 64: maximum cycles spent in REQ+WAIT_RSP before abort; must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill M-stage instruction (honoured only in IDLE)
- mem_rd_M  in  1  load in M stage
- mem_wr_M  in  1  store in M stage
- funct3_M  in  3  access size/sign (RV32I encoding)
- alu_o_M  in  32  byte address
- wr_data_M  in  32  store data (rs2)
- rd_data_M  out  32  extracted, extended load data
- stall_M  out  1  hold pipeline
- misalign_M  out  1  one-cycle exception flag
- bus_err_M  out  1  one-cycle timeout flag
- req_valid  out  1  request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned address ({alu_o_M[31:2],2'b00})
- req_be  out  4  byte enables
- req_wdata  out  32  lane-aligned write data
- rsp_valid  in  1  read data valid
- rsp_rdata  in  32  read word

Behaviour:
- Reset (rst=0, asynchronous, also mid-transaction): state IDLE; all outputs 0; internal address/be/wdata/data/timeout registers 0. After reset, the bus sees req_valid=0 immediately and any in-flight response is ignored.
- funct3: 000 B (signed), 001 H (signed), 010 W, 100 BU, 101 HU. 100 and 101 are legal for loads only. Any other code, or 100/101 on a store, is illegal.
- Alignment: H/HU require addr[0]=0; W requires addr[1:0]=0.
- If mem_wr_M and mem_rd_M are both 1, the access is a store.
- FSM: IDLE, REQ, WAIT_RSP, DONE.
- IDLE
  - No access, or flush=1: stall_M=0, no transaction.
  - Access that is misaligned or illegal: misalign_M=1 for this cycle, stall_M=0, rd_data_M=0, no bus request; stay IDLE.
  - Legal access: stall_M=1 combinationally. Register req_addr/be/wdata/we; next state REQ.
- REQ
  - req_valid=1, stall_M=1. Address, byte enables, write data and we are held stable until req_ready=1 is sampled.
  - On req_ready: store goes to DONE; load goes to WAIT_RSP.
  - req_valid is never withdrawn before acceptance.
- WAIT_RSP
  - stall_M=1. rsp_valid is sampled only in this state; a response in the same cycle as acceptance is not permitted.
  - On rsp_valid: capture the extracted result; next state DONE.
- DONE
  - stall_M=0. rd_data_M = captured result (0 for stores). Next state IDLE.
  - The pipeline advances this cycle. The next M-stage instruction is evaluated in the following IDLE cycle.
- Store lanes
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = halfword replicated ×2.
  - SW: be = 1111.
- Load extraction
  - Select byte addr[1:0] or half addr[1] from rsp_rdata.
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- Latency: load with req_ready and rsp_valid at the earliest legal cycle gives 3 stall cycles (IDLE, REQ, WAIT_RSP), then DONE. Store minimum is 2 stall cycles.
- Timeout
  - Counter clears on entering REQ and increments in REQ and WAIT_RSP.
  - When it reaches TIMEOUT_CYC: go to DONE, bus_err_M=1 in DONE, rd_data_M=0, req_valid drops.
  - A late rsp_valid after a timeout is ignored.
- Flush after IDLE has no effect: the transaction completes on the bus.
- rd_data_M is 0 in every state except DONE.
- misalign_M and bus_err_M are single-cycle pulses, never asserted together.

Test Plan:
- Reset mid-WAIT_RSP: drive rst=0 → req_valid, stall_M and all flags 0 immediately; a later rsp_valid is ignored; state is IDLE.
- LB, addr 0x1003, rsp_rdata 0x80FF_1234, req_ready/rsp_valid at the earliest legal cycle → req_addr 0x1000, req_be 1111-agnostic read; stall_M 3 cycles; DONE rd_data_M 0xFFFF_FF80.
- LHU, addr 0x2002, rsp_rdata 0xBEEF_0001 → rd_data_M 0x0000_BEEF. Then LW 0x2004, rsp 0x1234_5678 → 0x1234_5678.
- SH, addr 0x3002, wr_data_M 0xAAAA_5A5A, req_ready held low 4 cycles → req_valid, req_addr, be=1100, wdata=0x5A5A_5A5A stable throughout; stall_M=1 until DONE; rd_data_M=0.
- SW, addr 0x4001 → misalign_M=1 for one cycle, no req_valid, stall_M=0. LW at funct3=011 → same response.
- TIMEOUT_CYC=8, load with rsp_valid never asserted → bus_err_M pulses after 8 cycles in REQ+WAIT_RSP; rd_data_M=0; FSM returns to IDLE. flush=1 in IDLE with a pending load → no request issued.
